// File: rtl/tblock_dispatcher.sv
// Thread-block dispatcher: buffers allocations and spreads them round-robin over clusters,
// and merges per-cluster completions into one stream. Optional counters: TBLOCK_DISPATCH_PERF_EN.
module tblock_dispatcher_chk #(
  parameter int NumClusters = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  input logic                   allocate_warp_i,
  input logic                   warp_free_o,
  input logic [NumClusters-1:0] cl_allocate_warp_o,
  input logic [NumClusters-1:0] cl_tblock_done_ready_o
);
  a_no_drop: assert property (@(posedge clk_i) disable iff (rst_i)
    !(allocate_warp_i && !warp_free_o));
  a_alloc_onehot: assert property (@(posedge clk_i) $onehot0(cl_allocate_warp_o));
  a_grant_onehot: assert property (@(posedge clk_i) $onehot0(cl_tblock_done_ready_o));
endmodule

module tblock_dispatcher #(
  parameter int NumClusters    = 4,
  parameter int PcWidth        = 16,
  parameter int AddressWidth   = 32,
  parameter int TblockIdxBits  = 8,
  parameter int TgroupIdBits   = 8,
  parameter int AllocFifoDepth = 2,
  parameter int DoneFifoDepth  = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  output logic                                warp_free_o,
  input  logic                                allocate_warp_i,
  input  logic [PcWidth-1:0]                  allocate_pc_i,
  input  logic [AddressWidth-1:0]             allocate_dp_addr_i,
  input  logic [TblockIdxBits-1:0]            allocate_tblock_idx_i,
  input  logic [TgroupIdBits-1:0]             allocate_tgroup_id_i,
  input  logic [NumClusters-1:0]              cl_warp_free_i,
  output logic [NumClusters-1:0]              cl_allocate_warp_o,
  output logic [PcWidth-1:0]                  cl_allocate_pc_o,
  output logic [AddressWidth-1:0]             cl_allocate_dp_addr_o,
  output logic [TblockIdxBits-1:0]            cl_allocate_tblock_idx_o,
  output logic [TgroupIdBits-1:0]             cl_allocate_tgroup_id_o,
  input  logic [NumClusters-1:0]              cl_tblock_done_i,
  input  logic [NumClusters*TgroupIdBits-1:0] cl_tblock_done_id_i,
  output logic [NumClusters-1:0]              cl_tblock_done_ready_o,
  output logic                                tblock_done_o,
  output logic [TgroupIdBits-1:0]             tblock_done_id_o,
`ifdef TBLOCK_DISPATCH_PERF_EN
  output logic [31:0]                         perf_dispatched_o,
  output logic [31:0]                         perf_completed_o,
`endif
  input  logic                                tblock_done_ready_i
);
  localparam int CW  = (NumClusters > 1) ? $clog2(NumClusters) : 1;
  localparam int PW  = PcWidth + AddressWidth + TblockIdxBits + TgroupIdBits;
  localparam int AAW = (AllocFifoDepth > 1) ? $clog2(AllocFifoDepth) : 1;
  localparam int ACW = $clog2(AllocFifoDepth + 1);
  localparam int DAW = (DoneFifoDepth > 1) ? $clog2(DoneFifoDepth) : 1;
  localparam int DCW = $clog2(DoneFifoDepth + 1);

  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    return CW'(sum % NumClusters);
  endfunction

  function automatic logic [AAW-1:0] alloc_inc(input logic [AAW-1:0] p);
    return (p == AAW'(AllocFifoDepth - 1)) ? AAW'(0) : p + AAW'(1);
  endfunction

  function automatic logic [DAW-1:0] done_inc(input logic [DAW-1:0] p);
    return (p == DAW'(DoneFifoDepth - 1)) ? DAW'(0) : p + DAW'(1);
  endfunction

  logic [PW-1:0]           r_alloc_mem [AllocFifoDepth];
  logic [AAW-1:0]          r_alloc_rd;
  logic [AAW-1:0]          r_alloc_wr;
  logic [ACW-1:0]          r_alloc_cnt;
  logic [CW-1:0]           r_alloc_ptr;
  logic [TgroupIdBits-1:0] r_done_mem [DoneFifoDepth];
  logic [DAW-1:0]          r_done_rd;
  logic [DAW-1:0]          r_done_wr;
  logic [DCW-1:0]          r_done_cnt;
  logic [CW-1:0]           r_done_ptr;

  logic                    w_alloc_full;
  logic                    w_alloc_empty;
  logic                    w_alloc_push;
  logic [PW-1:0]           w_alloc_in;
  logic [PW-1:0]           w_alloc_head;
  logic                    w_issue;
  logic [CW-1:0]           w_issue_sel;
  logic                    w_done_full;
  logic                    w_done_empty;
  logic                    w_done_pop;
  logic                    w_grant;
  logic [CW-1:0]           w_grant_sel;
  logic [TgroupIdBits-1:0] w_grant_id;

  assign w_alloc_full  = (r_alloc_cnt == ACW'(AllocFifoDepth));
  assign w_alloc_empty = (r_alloc_cnt == ACW'(0));
  assign w_alloc_push  = allocate_warp_i && !w_alloc_full;
  assign w_alloc_in    = {allocate_pc_i, allocate_dp_addr_i, allocate_tblock_idx_i,
                          allocate_tgroup_id_i};
  assign w_alloc_head  = r_alloc_mem[r_alloc_rd];
  assign warp_free_o   = !w_alloc_full;

  assign w_done_full   = (r_done_cnt == DCW'(DoneFifoDepth));
  assign w_done_empty  = (r_done_cnt == DCW'(0));
  assign w_done_pop    = !w_done_empty && tblock_done_ready_i;
  assign w_grant_id    = cl_tblock_done_id_i[int'(w_grant_sel)*TgroupIdBits +: TgroupIdBits];

  // Pick the first free cluster at or after the allocation pointer; nothing in the reset cycle.
  always_comb begin
    w_issue     = 1'b0;
    w_issue_sel = r_alloc_ptr;
    if (!rst_i && !w_alloc_empty) begin
      for (int i = 0; i < NumClusters; i++) begin
        if (!w_issue && cl_warp_free_i[rr_idx(r_alloc_ptr, i)]) begin
          w_issue     = 1'b1;
          w_issue_sel = rr_idx(r_alloc_ptr, i);
        end else begin
          w_issue     = w_issue;
        end
      end
    end else begin
      w_issue = 1'b0;
    end
  end

  // Grant the first pending completion at or after the done pointer while there is room.
  always_comb begin
    w_grant     = 1'b0;
    w_grant_sel = r_done_ptr;
    if (!rst_i && !w_done_full) begin
      for (int i = 0; i < NumClusters; i++) begin
        if (!w_grant && cl_tblock_done_i[rr_idx(r_done_ptr, i)]) begin
          w_grant     = 1'b1;
          w_grant_sel = rr_idx(r_done_ptr, i);
        end else begin
          w_grant     = w_grant;
        end
      end
    end else begin
      w_grant = 1'b0;
    end
  end

  // Cluster-side outputs: payload is only driven alongside an allocate pulse.
  always_comb begin
    cl_allocate_warp_o       = {NumClusters{1'b0}};
    cl_allocate_pc_o         = {PcWidth{1'b0}};
    cl_allocate_dp_addr_o    = {AddressWidth{1'b0}};
    cl_allocate_tblock_idx_o = {TblockIdxBits{1'b0}};
    cl_allocate_tgroup_id_o  = {TgroupIdBits{1'b0}};
    cl_tblock_done_ready_o   = {NumClusters{1'b0}};
    if (w_issue) begin
      cl_allocate_warp_o[w_issue_sel] = 1'b1;
      {cl_allocate_pc_o, cl_allocate_dp_addr_o, cl_allocate_tblock_idx_o,
       cl_allocate_tgroup_id_o} = w_alloc_head;
    end else begin
      cl_allocate_warp_o = {NumClusters{1'b0}};
    end
    if (w_grant) begin
      cl_tblock_done_ready_o[w_grant_sel] = 1'b1;
    end else begin
      cl_tblock_done_ready_o = {NumClusters{1'b0}};
    end
  end

  assign tblock_done_o    = !w_done_empty;
  assign tblock_done_id_o = w_done_empty ? {TgroupIdBits{1'b0}} : r_done_mem[r_done_rd];

  // Buffer storage; contents are masked by the occupancy counts so need no reset.
  always_ff @(posedge clk_i) begin
    if (w_alloc_push) begin
      r_alloc_mem[r_alloc_wr] <= w_alloc_in;
    end
    if (w_grant) begin
      r_done_mem[r_done_wr] <= w_grant_id;
    end
  end

  // Allocation buffer pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_alloc_rd  <= AAW'(0);
      r_alloc_wr  <= AAW'(0);
      r_alloc_cnt <= ACW'(0);
      r_alloc_ptr <= CW'(0);
    end else begin
      if (w_alloc_push) r_alloc_wr <= alloc_inc(r_alloc_wr);
      if (w_issue) begin
        r_alloc_rd  <= alloc_inc(r_alloc_rd);
        r_alloc_ptr <= rr_idx(w_issue_sel, 1);
      end
      case ({w_alloc_push, w_issue})
        2'b10:   r_alloc_cnt <= r_alloc_cnt + ACW'(1);
        2'b01:   r_alloc_cnt <= r_alloc_cnt - ACW'(1);
        default: r_alloc_cnt <= r_alloc_cnt;
      endcase
    end
  end

  // Completion buffer pointers, occupancy and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_done_rd  <= DAW'(0);
      r_done_wr  <= DAW'(0);
      r_done_cnt <= DCW'(0);
      r_done_ptr <= CW'(0);
    end else begin
      if (w_grant) begin
        r_done_wr  <= done_inc(r_done_wr);
        r_done_ptr <= rr_idx(w_grant_sel, 1);
      end
      if (w_done_pop) r_done_rd <= done_inc(r_done_rd);
      case ({w_grant, w_done_pop})
        2'b10:   r_done_cnt <= r_done_cnt + DCW'(1);
        2'b01:   r_done_cnt <= r_done_cnt - DCW'(1);
        default: r_done_cnt <= r_done_cnt;
      endcase
    end
  end

`ifdef TBLOCK_DISPATCH_PERF_EN
  logic [31:0] r_perf_dispatched;
  logic [31:0] r_perf_completed;

  // Event counters; wrap naturally at 32 bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_dispatched <= 32'd0;
      r_perf_completed  <= 32'd0;
    end else begin
      if (w_issue)    r_perf_dispatched <= r_perf_dispatched + 32'd1;
      if (w_done_pop) r_perf_completed  <= r_perf_completed + 32'd1;
    end
  end

  assign perf_dispatched_o = r_perf_dispatched;
  assign perf_completed_o  = r_perf_completed;
`endif

  tblock_dispatcher_chk #(.NumClusters(NumClusters)) u_chk (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .allocate_warp_i        (allocate_warp_i),
    .warp_free_o            (warp_free_o),
    .cl_allocate_warp_o     (cl_allocate_warp_o),
    .cl_tblock_done_ready_o (cl_tblock_done_ready_o)
  );
endmodule

// File: doc/tblock_dispatcher.md
Name: tblock_dispatcher

Overview:
- Sits directly downstream of the control domain's thread-block allocation and completion interface, between it and NumClusters compute clusters.
- Buffers allocation requests and spreads them round-robin over clusters that report a free warp.
- Collects per-cluster thread-block completion events, arbitrates them round-robin and buffers them into the single completion stream back to the control domain.

Parameters:
- NumClusters, 4, number of compute clusters served (>=1)
- PcWidth, 16, program counter width
- AddressWidth, 32, data/parameter address width
- TblockIdxBits, 8, thread-block index width
- TgroupIdBits, 8, thread-group id width
- AllocFifoDepth, 2, allocation buffer entries (>=1)
- DoneFifoDepth, 4, completion buffer entries (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- warp_free_o  out  1  allocation buffer not full (ready to control domain)
- allocate_warp_i  in  1  allocation request (valid)
- allocate_pc_i  in  PcWidth  start PC
- allocate_dp_addr_i  in  AddressWidth  data/parameter address
- allocate_tblock_idx_i  in  TblockIdxBits  block index
- allocate_tgroup_id_i  in  TgroupIdBits  group id
- cl_warp_free_i  in  NumClusters  per-cluster free-warp flag
- cl_allocate_warp_o  out  NumClusters  one-hot allocate pulse
- cl_allocate_pc_o  out  PcWidth  broadcast payload, PC
- cl_allocate_dp_addr_o  out  AddressWidth  broadcast payload, address
- cl_allocate_tblock_idx_o  out  TblockIdxBits  broadcast payload, block index
- cl_allocate_tgroup_id_o  out  TgroupIdBits  broadcast payload, group id
- cl_tblock_done_i  in  NumClusters  per-cluster completion valid
- cl_tblock_done_id_i  in  NumClusters*TgroupIdBits  packed ids; cluster k at [k*TgroupIdBits +: TgroupIdBits]
- cl_tblock_done_ready_o  out  NumClusters  one-hot completion accept
- tblock_done_o  out  1  completion valid to control domain
- tblock_done_id_o  out  TgroupIdBits  completion id
- tblock_done_ready_i  in  1  control domain accepts completion

Behaviour:
Reset:
- All FIFOs empty; both round-robin pointers = 0.
- warp_free_o=1, cl_allocate_warp_o=0, cl_tblock_done_ready_o=0, tblock_done_o=0.
- Payload outputs and tblock_done_id_o are 0 while idle.
- Reset mid-operation discards all buffered entries; no pulse is issued in the reset cycle.

Allocation path:
- warp_free_o = !alloc_full, registered-state only; no combinational path from cluster inputs.
- Push when allocate_warp_i && warp_free_o. A request while warp_free_o=0 is dropped and flagged by assertion.
- Issue: head valid and any cl_warp_free_i set. Select the first set bit searching from alloc_ptr upward with wrap.
- On issue, the same cycle: cl_allocate_warp_o[sel]=1 for exactly one cycle, payload outputs = head, pop, alloc_ptr <= (sel+1) mod NumClusters.
- No free cluster: hold the head, outputs 0, pointer unchanged.
- Simultaneous push and pop when full is not possible (warp_free_o=0). When not full, both happen in the same cycle.
- Latency: request cycle N -> earliest cluster pulse N+1. Sustained throughput 1/cycle for AllocFifoDepth>=2.

Completion path:
- When done FIFO not full: grant the first set cl_tblock_done_i searching from done_ptr with wrap.
- Grant is combinational in that cycle: cl_tblock_done_ready_o[g]=1, push cl id g, done_ptr <= (g+1) mod NumClusters.
- FIFO full: all ready=0 and the pointer holds.
- tblock_done_o = !done_empty; tblock_done_id_o = head. Pop on tblock_done_o && tblock_done_ready_i.
- A pop in the same cycle as full re-enables the grant only from the next cycle (full is registered).
- Latency: cluster done N -> tblock_done_o N+1.
- Clusters hold valid and id stable until ready.

Optional Feature:
TBLOCK_DISPATCH_PERF_EN
- Defined: adds outputs perf_dispatched_o [31:0] and perf_completed_o [31:0].
  - perf_dispatched_o counts cluster allocate pulses; perf_completed_o counts control-domain completion handshakes.
  - Both reset to 0, wrap 0xFFFFFFFF -> 0, update the cycle after the event.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, all cl_warp_free_i=4'b1111, 4 back-to-back allocations with tgroup_id 1..4 -> pulses on clusters 0,1,2,3 in consecutive cycles with matching ids; first pulse 1 cycle after the first request.
- cl_warp_free_i=4'b0100, allocate pc=0x0040 -> only cl_allocate_warp_o[2] pulses with pc 0x0040; alloc_ptr becomes 3.
- cl_warp_free_i=0, 3 requests -> warp_free_o drops after 2 accepted. Set cl_warp_free_i=4'b0001 -> both issue to cluster 0 in order, and warp_free_o rises the cycle after the first pop.
- All 4 clusters assert done with ids 0xA0..0xA3, tblock_done_ready_i=0 -> grants in order 0,1,2,3 over 4 cycles, FIFO full, then all ready=0. Raise ready -> ids emitted A0,A1,A2,A3.
- Clusters 1 and 3 assert done continuously, ready_i=1 -> grants alternate 1,3,1,3 with no starvation.
- rst_i pulsed with 2 allocations and 3 completions buffered -> next cycle warp_free_o=1, tblock_done_o=0, no cluster pulse.
